// File: rtl/stopwatch_bcd_entry.sv
// Keypad BCD preset entry for the stopwatch: collects MM SS CC digits,
// range-checks them, converts to binary and offers them on a load handshake.
module stopwatch_bcd_entry #(
   parameter int MAX_S_TEN = 5,
   parameter int MAX_M_TEN = 9
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        digit_valid,
   input  logic [3:0]  digit,
   input  logic        clear,
   input  logic        commit,
   input  logic        load_ready,
   output logic [23:0] entry_bcd,
   output logic [2:0]  digit_cnt,
   output logic        busy,
   output logic        load_valid,
   output logic [6:0]  min,
   output logic [5:0]  sec,
   output logic [6:0]  centis,
   output logic        err,
   output logic        digit_err
);

   typedef enum logic [1:0] {
      ENTRY = 2'd0,
      CHECK = 2'd1,
      CONV  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam logic [3:0] S_LIM = 4'(MAX_S_TEN);
   localparam logic [3:0] M_LIM = 4'(MAX_M_TEN);

   state_t      state;
   state_t      state_n;
   logic [1:0]  idx;
   logic [1:0]  idx_n;
   logic [23:0] entry_n;
   logic [2:0]  cnt_n;
   logic        err_n;
   logic        derr_n;
   logic        lv_n;
   logic        busy_n;
   logic        ld_n;
   logic        bad;
   logic [3:0]  ten;
   logic [3:0]  one;
   logic [6:0]  sum;
   logic [6:0]  sh_min;
   logic [5:0]  sh_sec;

   // Range check of the buffered digits, evaluated while in CHECK
   always_comb begin
      bad = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (entry_bcd[i*4 +: 4] > 4'd9) bad = 1'b1;
      end
      if (entry_bcd[15:12] > S_LIM) bad = 1'b1;
      if (entry_bcd[23:20] > M_LIM) bad = 1'b1;
   end

   // Shared x10 adder; the field is picked by the conversion step
   always_comb begin
      ten = entry_bcd[7:4];
      one = entry_bcd[3:0];
      case (idx)
         2'd0: begin
            ten = entry_bcd[23:20];
            one = entry_bcd[19:16];
         end
         2'd1: begin
            ten = entry_bcd[15:12];
            one = entry_bcd[11:8];
         end
         default: begin
            ten = entry_bcd[7:4];
            one = entry_bcd[3:0];
         end
      endcase
      sum = {ten, 3'b000} + {2'b00, ten, 1'b0} + {3'b000, one};
   end

   // Next-state and next-output decode
   always_comb begin
      state_n = state;
      idx_n   = idx;
      entry_n = entry_bcd;
      cnt_n   = digit_cnt;
      err_n   = 1'b0;
      derr_n  = 1'b0;
      lv_n    = load_valid;
      ld_n    = 1'b0;
      case (state)
         ENTRY: begin
            if (clear) begin
               entry_n = '0;
               cnt_n   = '0;
            end else if (commit) begin
               state_n = CHECK;
            end else if (digit_valid) begin
               if (digit <= 4'd9) begin
                  entry_n = {entry_bcd[19:0], digit};
                  if (digit_cnt != 3'd6) cnt_n = digit_cnt + 3'd1;
               end else begin
                  derr_n = 1'b1;
               end
            end
         end
         CHECK: begin
            if (clear) begin
               state_n = ENTRY;
               entry_n = '0;
               cnt_n   = '0;
            end else if (bad) begin
               state_n = ENTRY;
               err_n   = 1'b1;
            end else begin
               state_n = CONV;
               idx_n   = 2'd0;
            end
         end
         CONV: begin
            if (clear) begin
               state_n = ENTRY;
               entry_n = '0;
               cnt_n   = '0;
               idx_n   = 2'd0;
            end else if (idx == 2'd2) begin
               state_n = HOLD;
               idx_n   = 2'd0;
               ld_n    = 1'b1;
               lv_n    = 1'b1;
            end else begin
               idx_n = idx + 2'd1;
            end
         end
         HOLD: begin
            if (clear || load_ready) begin
               state_n = ENTRY;
               lv_n    = 1'b0;
               entry_n = '0;
               cnt_n   = '0;
            end
         end
         default: begin
            state_n = ENTRY;
         end
      endcase
      busy_n = (state_n != ENTRY);
   end

   // Control and entry-buffer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ENTRY;
         idx        <= 2'd0;
         entry_bcd  <= '0;
         digit_cnt  <= '0;
         err        <= 1'b0;
         digit_err  <= 1'b0;
         load_valid <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         entry_bcd  <= entry_n;
         digit_cnt  <= cnt_n;
         err        <= err_n;
         digit_err  <= derr_n;
         load_valid <= lv_n;
         busy       <= busy_n;
      end
   end

   // Shadow registers and atomic update of the preset outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_min <= '0;
         sh_sec <= '0;
         min    <= '0;
         sec    <= '0;
         centis <= '0;
      end else begin
         if (state == CONV && !clear) begin
            if (idx == 2'd0) sh_min <= sum;
            if (idx == 2'd1) sh_sec <= sum[5:0];
         end
         if (ld_n) begin
            min    <= sh_min;
            sec    <= sh_sec;
            centis <= sum;
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_bcd_entry.sv
// Scoreboard bench for stopwatch_bcd_entry: expected presets are queued
// at commit and compared when the load handshake completes.
module tb_stopwatch_bcd_entry;

   typedef struct {
      int m;
      int s;
      int c;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        digit_valid;
   logic [3:0]  digit;
   logic        clear;
   logic        commit;
   logic        load_ready;
   logic [23:0] entry_bcd;
   logic [2:0]  digit_cnt;
   logic        busy;
   logic        load_valid;
   logic [6:0]  min;
   logic [5:0]  sec;
   logic [6:0]  centis;
   logic        err;
   logic        digit_err;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   stopwatch_bcd_entry #(
      .MAX_S_TEN(5),
      .MAX_M_TEN(9)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .digit_valid(digit_valid),
      .digit(digit),
      .clear(clear),
      .commit(commit),
      .load_ready(load_ready),
      .entry_bcd(entry_bcd),
      .digit_cnt(digit_cnt),
      .busy(busy),
      .load_valid(load_valid),
      .min(min),
      .sec(sec),
      .centis(centis),
      .err(err),
      .digit_err(digit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] d);
      digit_valid = 1'b1;
      digit = d;
      tick();
      digit_valid = 1'b0;
   endtask

   task automatic push(input int m, input int s, input int c);
      exp_t e;
      e.m = m;
      e.s = s;
      e.c = c;
      sb.push_back(e);
   endtask

   // Scoreboard pop on every completed load handshake
   always @(negedge clk) begin
      if (rst_n && load_valid && load_ready) begin
         if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("ld_min", 32'(min), 32'(e.m));
            chk("ld_sec", 32'(sec), 32'(e.s));
            chk("ld_cs", 32'(centis), 32'(e.c));
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      digit_valid = 1'b0;
      digit = 4'd0;
      clear = 1'b0;
      commit = 1'b0;
      load_ready = 1'b0;
      tick();
      tick();
      chk("rst_entry", 32'(entry_bcd), 32'h0);
      chk("rst_cnt", 32'(digit_cnt), 32'd0);
      chk("rst_lv", 32'(load_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_min", 32'(min), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst_n = 1'b1;
      tick();

      // 12:34.56 with immediate acceptance
      for (int i = 1; i <= 6; i++) send(4'(i));
      chk("t1_entry", 32'(entry_bcd), 32'h123456);
      chk("t1_cnt", 32'(digit_cnt), 32'd6);
      commit = 1'b1;
      push(12, 34, 56);
      tick();
      commit = 1'b0;
      load_ready = 1'b1;
      chk("t1_busy", 32'(busy), 32'd1);
      for (int i = 1; i <= 4; i++) begin
         chk("t1_lv_lo", 32'(load_valid), 32'd0);
         tick();
      end
      chk("t1_lv_hi", 32'(load_valid), 32'd1);
      tick();
      load_ready = 1'b0;
      chk("t1_lv_end", 32'(load_valid), 32'd0);
      chk("t1_entry0", 32'(entry_bcd), 32'h0);
      chk("t1_cnt0", 32'(digit_cnt), 32'd0);
      chk("t1_busy0", 32'(busy), 32'd0);
      chk("t1_min", 32'(min), 32'd12);

      // Seven digits, seconds out of range
      for (int i = 9; i >= 3; i--) send(4'(i));
      chk("t2_entry", 32'(entry_bcd), 32'h876543);
      chk("t2_cnt", 32'(digit_cnt), 32'd6);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      chk("t2_err_n1", 32'(err), 32'd0);
      tick();
      chk("t2_err_n2", 32'(err), 32'd1);
      chk("t2_lv", 32'(load_valid), 32'd0);
      tick();
      chk("t2_err_n3", 32'(err), 32'd0);
      chk("t2_keep", 32'(entry_bcd), 32'h876543);
      chk("t2_busy", 32'(busy), 32'd0);
      chk("t2_min", 32'(min), 32'd12);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t2_clr", 32'(entry_bcd), 32'h0);

      // Short entry held off by the core
      send(4'd4);
      send(4'd5);
      commit = 1'b1;
      push(0, 0, 45);
      tick();
      commit = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t3_lv", 32'(load_valid), 32'd1);
      for (int i = 0; i < 10; i++) begin
         digit_valid = i[0];
         digit = 4'd7;
         commit = ~i[0];
         tick();
         chk("t3_lv_hold", 32'(load_valid), 32'd1);
         chk("t3_cs_hold", 32'(centis), 32'd45);
         chk("t3_buf", 32'(entry_bcd), 32'h45);
         chk("t3_derr", 32'(digit_err), 32'd0);
      end
      digit_valid = 1'b0;
      commit = 1'b0;
      load_ready = 1'b1;
      tick();
      load_ready = 1'b0;
      chk("t3_lv_drop", 32'(load_valid), 32'd0);
      chk("t3_min", 32'(min), 32'd0);

      // Non-BCD digit, then clear+commit+digit together
      send(4'd3);
      send(4'hB);
      chk("t4_derr", 32'(digit_err), 32'd1);
      chk("t4_buf", 32'(entry_bcd), 32'h3);
      chk("t4_cnt", 32'(digit_cnt), 32'd1);
      tick();
      chk("t4_derr0", 32'(digit_err), 32'd0);
      clear = 1'b1;
      commit = 1'b1;
      digit_valid = 1'b1;
      digit = 4'd8;
      tick();
      clear = 1'b0;
      commit = 1'b0;
      digit_valid = 1'b0;
      chk("t4_pri_buf", 32'(entry_bcd), 32'h0);
      chk("t4_pri_cnt", 32'(digit_cnt), 32'd0);
      chk("t4_pri_busy", 32'(busy), 32'd0);
      tick();
      chk("t4_pri_busy2", 32'(busy), 32'd0);

      // Load 01:02.03, then abort a second conversion mid-CONV
      send(4'd0); send(4'd1); send(4'd0);
      send(4'd2); send(4'd0); send(4'd3);
      commit = 1'b1;
      push(1, 2, 3);
      tick();
      commit = 1'b0;
      load_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      load_ready = 1'b0;
      chk("t5_min", 32'(min), 32'd1);
      send(4'd5); send(4'd9); send(4'd5);
      send(4'd9); send(4'd9); send(4'd9);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      tick();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_buf", 32'(entry_bcd), 32'h0);
      for (int i = 0; i < 4; i++) begin
         chk("t5_lv", 32'(load_valid), 32'd0);
         chk("t5_err", 32'(err), 32'd0);
         tick();
      end
      chk("t5_keep_m", 32'(min), 32'd1);
      chk("t5_keep_s", 32'(sec), 32'd2);
      chk("t5_keep_c", 32'(centis), 32'd3);

      // Asynchronous reset while holding a preset
      send(4'd2); send(4'd2); send(4'd3);
      send(4'd3); send(4'd4); send(4'd4);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("t6_lv", 32'(load_valid), 32'd1);
      chk("t6_min", 32'(min), 32'd22);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_lv", 32'(load_valid), 32'd0);
      chk("t6_rst_min", 32'(min), 32'd0);
      chk("t6_rst_sec", 32'(sec), 32'd0);
      chk("t6_rst_cs", 32'(centis), 32'd0);
      chk("t6_rst_buf", 32'(entry_bcd), 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      send(4'd0); send(4'd0); send(4'd5);
      send(4'd9); send(4'd9); send(4'd9);
      commit = 1'b1;
      push(0, 59, 99);
      tick();
      commit = 1'b0;
      load_ready = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      load_ready = 1'b0;
      chk("t6_lv_end", 32'(load_valid), 32'd0);
      chk("t6_sec", 32'(sec), 32'd59);
      tick();
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
